logic_32_bit_seq: RTL

//  Multi-cycle 32-bit bitwise logic unit with valid/ready handshakes on both sides.

---
 rtl/logic_32_bit_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/logic_32_bit_seq.sv
// Multi-cycle 32-bit bitwise logic unit (AND/OR/NOR/INV), one SLICE_W-bit slice per clock,
// with valid/ready handshakes on request and result sides and a registered ZERO flag.
module logic_32_bit_seq #(
  parameter int SLICE_W = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [1:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] Y,
  output logic        ZERO
);

  localparam int NSLICE = 32 / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  generate
    if (!((SLICE_W == 1) || (SLICE_W == 2) || (SLICE_W == 4) ||
          (SLICE_W == 8) || (SLICE_W == 16) || (SLICE_W == 32))) begin : g_bad_slice_w
      $error("logic_32_bit_seq: SLICE_W must be 1, 2, 4, 8, 16 or 32");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [1:0]          op_q;
  logic [31:0]         a_q;
  logic [31:0]         b_q;
  logic [31:0]         y_q;
  logic                zero_q;
  logic                out_valid_q;
  logic                in_ready_q;
  logic [SLICE_W-1:0]  slice_s;
  logic [31:0]         y_d;

  function automatic logic [SLICE_W-1:0] slice_op(input logic [1:0] op,
                                                  input logic [SLICE_W-1:0] a,
                                                  input logic [SLICE_W-1:0] b);
    logic [SLICE_W-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = ~(a | b);
      2'b11:   r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Result word with the current slice replaced by its freshly computed value.
  always_comb begin
    slice_s = slice_op(op_q, a_q[cnt_q*SLICE_W +: SLICE_W], b_q[cnt_q*SLICE_W +: SLICE_W]);
    y_d = y_q;
    y_d[cnt_q*SLICE_W +: SLICE_W] = slice_s;
  end

  // Control FSM plus all registered outputs; IN_READY comes up on the first edge after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= 2'b00;
      a_q         <= 32'h0000_0000;
      b_q         <= 32'h0000_0000;
      y_q         <= 32'h0000_0000;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (IN_VALID && in_ready_q) begin
            op_q       <= OP;
            a_q        <= A;
            b_q        <= B;
            y_q        <= 32'h0000_0000;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_BUSY;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          y_q <= y_d;
          if (cnt_q == LAST_SLICE) begin
            out_valid_q <= 1'b1;
            zero_q      <= (y_d == 32'h0000_0000);
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          // No bypass: a new request can only be taken from IDLE on a later edge.
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign Y         = y_q;
  assign ZERO      = zero_q;

endmodule
